aes_job_arbiter: RTL and testbench



---
 rtl/aes_ctrl_pkg.sv | 19 +
 rtl/aes_job_arbiter_if.sv | 27 ++
 rtl/aes_rr_arb2.sv | 25 ++
 rtl/aes_job_arbiter.sv | 130 +++++++++++++
 tb/tb_aes_job_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES job arbiter.
// Contents: controller state enum, block width, watchdog counter width helper.
package aes_ctrl_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StBusy  = 2'd2,
        StResp  = 2'd3
    } aes_state_e;

    // Width of a counter that must hold 0 .. cycles-1; never narrower than 1 bit.
    function automatic int unsigned to_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Per-requester job + response channel.
// master: requester side (drives job fields and rsp_ready).
// slave:  arbiter side (drives ready and the response fields).
interface aes_job_arbiter_if;
    import aes_ctrl_pkg::*;

    logic                 valid;
    logic                 ready;
    logic                 decrypt;
    logic [AES_BLK_W-1:0] key;
    logic [AES_BLK_W-1:0] data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [AES_BLK_W-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        output valid, decrypt, key, data, rsp_ready,
        input  ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  valid, decrypt, key, data, rsp_ready,
        output ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: valid[1:0] requests, rr_last last granted index, enable gates the grant,
//        grant selected index, gnt_onehot one-hot grant (zero when disabled or idle).
module aes_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       enable,
    output logic       grant,
    output logic [1:0] gnt_onehot
);

    always_comb begin
        grant      = 1'b0;
        gnt_onehot = 2'b00;
        if (valid == 2'b11) begin
            grant = ~rr_last;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
        if (enable && (valid != 2'b00)) begin
            gnt_onehot = grant ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES core between two requesters with round-robin arbitration and a
// completion watchdog.
// Ports: clk/rst_n (sync, active-low); req0/req1 job+response channels;
//        core_* drive and observe the AES core; busy_o = not idle;
//        grant_o = requester owning the current job.
module aes_job_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned BLK_W          = AES_BLK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_job_arbiter_if.slave req0,
    aes_job_arbiter_if.slave req1,
    output logic             core_start_o,
    output logic             core_decrypt_o,
    output logic [BLK_W-1:0] core_key_o,
    output logic [BLK_W-1:0] core_data_o,
    input  logic [BLK_W-1:0] core_data_i,
    input  logic             core_ready_i,
    output logic             busy_o,
    output logic             grant_o
);

    localparam int unsigned    TO_W     = to_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    aes_state_e       state_q, state_d;
    logic             rr_last;
    logic             ready_q;
    logic [TO_W-1:0]  cnt;
    logic [BLK_W-1:0] result;
    logic             err;

    logic             arb_grant;
    logic [1:0]       gnt_onehot;
    logic             accept;
    logic             done;
    logic             timeout;
    logic             rsp_hs;

    aes_rr_arb2 u_arb (
        .valid      ({req1.valid, req0.valid}),
        .rr_last    (rr_last),
        .enable     (state_q == StIdle),
        .grant      (arb_grant),
        .gnt_onehot (gnt_onehot)
    );

    assign accept  = |gnt_onehot;
    // Completion is a rising edge of core ready; a level already high at issue is ignored.
    assign done    = (state_q == StBusy) && core_ready_i && !ready_q;
    assign timeout = (state_q == StBusy) && (cnt == CNT_LAST) && !done;
    assign rsp_hs  = (state_q == StResp) && (grant_o ? req1.rsp_ready : req0.rsp_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StBusy;
            StBusy:  if (done || timeout) state_d = StResp;
            StResp:  if (rsp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Job operands, arbitration history, watchdog and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last        <= 1'b1;
            grant_o        <= 1'b0;
            core_key_o     <= '0;
            core_data_o    <= '0;
            core_decrypt_o <= 1'b0;
            ready_q        <= 1'b0;
            cnt            <= '0;
            result         <= '0;
            err            <= 1'b0;
        end else begin
            if (accept) begin
                core_key_o     <= arb_grant ? req1.key : req0.key;
                core_data_o    <= arb_grant ? req1.data : req0.data;
                core_decrypt_o <= arb_grant ? req1.decrypt : req0.decrypt;
                grant_o        <= arb_grant;
                rr_last        <= arb_grant;
            end
            if (state_q == StIssue) begin
                ready_q <= core_ready_i;
                cnt     <= '0;
            end
            if (state_q == StBusy) begin
                ready_q <= core_ready_i;
                cnt     <= cnt + TO_W'(1);
                if (done) begin
                    result <= core_data_i;
                    err    <= 1'b0;
                end else if (timeout) begin
                    result <= '0;
                    err    <= 1'b1;
                end
            end
        end
    end

    // Outputs.
    always_comb begin
        core_start_o   = (state_q == StIssue);
        busy_o         = (state_q != StIdle);
        req0.ready     = gnt_onehot[0];
        req1.ready     = gnt_onehot[1];
        req0.rsp_valid = (state_q == StResp) && !grant_o;
        req1.rsp_valid = (state_q == StResp) && grant_o;
        req0.rsp_data  = req0.rsp_valid ? result : '0;
        req1.rsp_data  = req1.rsp_valid ? result : '0;
        req0.rsp_err   = req0.rsp_valid && err;
        req1.rsp_err   = req1.rsp_valid && err;
    end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: directed scenarios followed by a
// randomized phase, checked against a job-level reference model.
module tb_aes_job_arbiter;

    localparam int T = 64;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_job_arbiter_if req0_if ();
    aes_job_arbiter_if req1_if ();

    logic         core_start, core_decrypt, busy, grant;
    logic [127:0] core_key, core_data;
    logic [127:0] core_rdata = '0;
    logic         core_ready = 1'b0;

    aes_job_arbiter #(
        .TIMEOUT_CYCLES (T),
        .BLK_W          (128)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0           (req0_if),
        .req1           (req1_if),
        .core_start_o   (core_start),
        .core_decrypt_o (core_decrypt),
        .core_key_o     (core_key),
        .core_data_o    (core_data),
        .core_data_i    (core_rdata),
        .core_ready_i   (core_ready),
        .busy_o         (busy),
        .grant_o        (grant)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h required %h (failure #%0d)", tag, obs, exp, failed);
        end
    endtask

    // Behavioural AES core: the FIPS-197 vector both ways, a keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                             input logic dec);
        if (k == FIPS_KEY && !dec && d == FIPS_PT) return FIPS_CT;
        if (k == FIPS_KEY && dec && d == FIPS_CT) return FIPS_PT;
        return k ^ {d[63:0], d[127:64]} ^ {128{dec}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core model: ready rises lat cycles after start. In hi_mode ready is left high
    // through start, drops 3 cycles later, then rises at lat.
    int lat     = 11;
    bit hi_mode = 1'b0;
    bit active  = 1'b0;
    int t_run   = 0;

    always @(negedge clk) begin
        if (core_start) begin
            active     <= 1'b1;
            t_run      <= 1;
            core_rdata <= rnd128();
            if (!hi_mode) core_ready <= 1'b0;
        end else if (active) begin
            if (t_run >= lat) begin
                core_ready <= 1'b1;
                core_rdata <= core_fn(core_key, core_data, core_decrypt);
                active     <= 1'b0;
            end else if (hi_mode && t_run >= 3) begin
                core_ready <= 1'b0;
            end
            t_run <= t_run + 1;
        end
    end

    // Requester-side model state.
    logic [127:0] jkey [2];
    logic [127:0] jdat [2];
    logic         jdec [2];
    bit           pend [2];
    bit           rr_last_m = 1'b1;

    task automatic drive(input int p);
        if (p == 0) begin
            req0_if.valid = pend[0]; req0_if.key = jkey[0];
            req0_if.data = jdat[0]; req0_if.decrypt = jdec[0];
        end else begin
            req1_if.valid = pend[1]; req1_if.key = jkey[1];
            req1_if.data = jdat[1]; req1_if.decrypt = jdec[1];
        end
    endtask

    task automatic set_job(input int p, input logic [127:0] k, input logic [127:0] d,
                           input logic dec);
        jkey[p] = k; jdat[p] = d; jdec[p] = dec; pend[p] = 1'b1;
        drive(p);
    endtask

    task automatic new_job(input int p);
        set_job(p, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) req0_if.rsp_ready = v; else req1_if.rsp_ready = v;
    endtask

    function automatic logic rspv(input int p);
        return (p == 0) ? req0_if.rsp_valid : req1_if.rsp_valid;
    endfunction
    function automatic logic [127:0] rspd(input int p);
        return (p == 0) ? req0_if.rsp_data : req1_if.rsp_data;
    endfunction
    function automatic logic rspe(input int p);
        return (p == 0) ? req0_if.rsp_err : req1_if.rsp_err;
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_grant"}, 128'(grant), 128'(0));
        check({tag, "_start"}, 128'(core_start), 128'(0));
        check({tag, "_ckey"}, core_key, 128'(0));
        check({tag, "_cdata"}, core_data, 128'(0));
        check({tag, "_cdec"}, 128'(core_decrypt), 128'(0));
        check({tag, "_rsp"}, 128'({req1_if.rsp_valid, req1_if.rsp_err, req0_if.rsp_valid,
                                   req0_if.rsp_err}), 128'(0));
        check({tag, "_rspd"}, req0_if.rsp_data | req1_if.rsp_data, 128'(0));
        check({tag, "_rdy"}, 128'({req1_if.ready, req0_if.ready}), 128'(0));
    endtask

    // One complete job: arbitration, issue, completion/timeout, response with
    // backpressure. add_p: -1 none, 0/1 present a new job on that port after accept,
    // 2 re-present on the granted port. Called and returns on a negedge.
    task automatic serve(input int lat_i, input bit hi_i, input int bp, input int add_p,
                         output logic [127:0] got);
        int           g, n, exp_n;
        logic [127:0] exp_d, acc_key, acc_dat;
        logic         exp_e, acc_dec;
        logic [1:0]   exp_oh, nxt;
        bit           bad;

        g       = (pend[0] && pend[1]) ? (rr_last_m ? 0 : 1) : (pend[0] ? 0 : 1);
        exp_oh  = (g == 1) ? 2'b10 : 2'b01;
        acc_key = jkey[g]; acc_dat = jdat[g]; acc_dec = jdec[g];
        exp_e   = (lat_i > T);
        exp_d   = exp_e ? 128'(0) : core_fn(acc_key, acc_dat, acc_dec);
        exp_n   = ((lat_i > T) ? T : lat_i) + 1;
        lat     = lat_i;
        hi_mode = hi_i;

        #1;
        n = 0;
        while (!(req0_if.ready || req1_if.ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("accept_onehot", 128'({req1_if.ready, req0_if.ready}), 128'(exp_oh));

        @(posedge clk); #1;
        pend[g]   = 1'b0;
        rr_last_m = (g == 1);
        if (add_p == 2) new_job(g);
        else if (add_p >= 0) new_job(add_p);
        if (!pend[g]) begin
            jkey[g] = rnd128(); jdat[g] = rnd128(); drive(g);
        end

        @(negedge clk);
        check("start_issue", 128'(core_start), 128'(1));
        check("grant_o", 128'(grant), 128'(g));
        check("core_key", core_key, acc_key);
        check("core_data", core_data, acc_dat);
        check("core_decrypt", 128'(core_decrypt), 128'(acc_dec));

        n = 0; bad = 1'b0;
        do begin
            @(negedge clk); n++;
            if (core_start || req0_if.ready || req1_if.ready) bad = 1'b1;
        end while (!(req0_if.rsp_valid || req1_if.rsp_valid) && n < 300);
        check("quiet_while_busy", 128'(bad), 128'(0));
        check("rsp_latency", 128'(n), 128'(exp_n));
        check("rsp_valid", 128'(rspv(g)), 128'(1));
        check("rsp_other_valid", 128'(rspv(1 - g)), 128'(0));
        check("rsp_data", rspd(g), exp_d);
        check("rsp_err", 128'(rspe(g)), 128'(exp_e));
        got = rspd(g);

        bad = 1'b0;
        repeat (bp) begin
            @(negedge clk);
            if (!rspv(g) || rspd(g) !== exp_d || rspe(g) !== exp_e || rspv(1 - g) ||
                req0_if.ready || req1_if.ready) bad = 1'b1;
        end
        check("rsp_hold", 128'(bad), 128'(0));

        set_rsp_ready(g, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(g, 1'b0);
        @(negedge clk);
        if (pend[0] && pend[1]) nxt = rr_last_m ? 2'b01 : 2'b10;
        else nxt = {pend[1], pend[0]};
        check("rsp_drop", 128'({req1_if.rsp_valid, req0_if.rsp_valid}), 128'(0));
        check("idle_after_rsp", 128'(busy), 128'(0));
        check("next_ready", 128'({req1_if.ready, req0_if.ready}), 128'(nxt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [127:0] got;
        int           n;
        bit           bad;

        pend[0] = 1'b0; pend[1] = 1'b0;
        jkey[0] = '0; jkey[1] = '0; jdat[0] = '0; jdat[1] = '0; jdec[0] = 1'b0; jdec[1] = 1'b0;
        drive(0); drive(1);
        req0_if.rsp_ready = 1'b0; req1_if.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;

        // FIPS-197 encrypt on req0.
        set_job(0, FIPS_KEY, FIPS_PT, 1'b0);
        serve(11, 1'b0, 2, -1, got);
        check("fips_ct", got, FIPS_CT);

        // Fairness from reset: both requesters stay valid for four jobs.
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; rr_last_m = 1'b1;
        new_job(0); new_job(1);
        serve(3, 1'b0, 1, 2, got);
        serve(4, 1'b0, 0, 2, got);
        serve(2, 1'b0, 1, -1, got);
        serve(5, 1'b0, 0, -1, got);

        // Watchdog: core never completes.
        new_job(0);
        serve(1000, 1'b0, 2, -1, got);

        // Backpressure on rsp0 while req1 waits.
        new_job(0);
        serve(5, 1'b0, 20, 1, got);
        serve(4, 1'b0, 0, -1, got);

        // Reset while BUSY; the late core edge must be ignored.
        new_job(0);
        lat = 20; hi_mode = 1'b0;
        #1;
        n = 0;
        while (!req0_if.ready && n < 10) begin @(negedge clk); #1; n++; end
        check("rst_accept", 128'(req0_if.ready), 128'(1));
        @(posedge clk); #1;
        pend[0] = 1'b0; drive(0);
        repeat (5) @(negedge clk);
        check("busy_before_rst", 128'(busy), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_last_m = 1'b1;
        check_reset_outs("midrst");
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (req0_if.rsp_valid || req1_if.rsp_valid || busy) bad = 1'b1;
        end
        check("no_late_rsp", 128'(bad), 128'(0));
        new_job(0); new_job(1);
        serve(6, 1'b0, 0, -1, got);
        serve(3, 1'b0, 0, -1, got);

        // Decrypt with core ready already high at issue.
        set_job(0, rnd128(), rnd128(), 1'b1);
        serve(10, 1'b1, 0, -1, got);

        // Completion edge on the same cycle as the timeout.
        new_job(1);
        serve(T, 1'b0, 0, -1, got);

        // Randomized jobs.
        for (int i = 0; i < 24; i++) begin
            int  r, l, bp, add;
            bit  hi;
            if (!pend[0] && !pend[1]) new_job(int'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) new_job(int'($urandom_range(0, 1)));
            r   = int'($urandom_range(0, 9));
            l   = (r < 7) ? int'($urandom_range(1, 20)) : ((r == 7) ? T : ((r == 8) ? T + 1 : T - 1));
            hi  = core_ready && (l >= 5) && ($urandom_range(0, 1) == 1);
            bp  = int'($urandom_range(0, 4));
            r   = int'($urandom_range(0, 5));
            add = (r == 0) ? 2 : ((r == 1) ? 0 : ((r == 2) ? 1 : -1));
            serve(l, hi, bp, add, got);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
